// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_stage
// Description : Instruction-fetch stage with IF/ID pipeline register.
//               Issues one request at a time to instruction memory, holds
//               the address stable until imem_ready, parks a returned word
//               while decode stalls, and flushes IF/ID on a branch redirect.
//               Optional performance counter is enabled by the macro
//               IF_PERF_CNT_EN; without it fetch_count is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_stage #(
  parameter logic [11:0] RESET_PC  = 12'h000,
  parameter logic [11:0] PC_STEP   = 12'd4,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [11:0] branch_addr,
  output logic        imem_req,
  output logic [11:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction,
  output logic [11:0] PC,
  output logic        id_valid,
  output logic [15:0] fetch_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [11:0] fetch_pc_q, fetch_pc_d;
  logic        pend_q, pend_d;
  logic [11:0] pend_addr_q, pend_addr_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [11:0] hold_pc_q, hold_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [11:0] pc_q, pc_d;
  logic        valid_q, valid_d;

  logic w_in_fetch;
  logic w_in_hold;
  logic w_word_ok;   // word returned with no redirect in flight
  logic w_take;      // word goes straight into IF/ID
  logic w_park;      // word goes into the hold buffer
  logic w_unpark;    // hold buffer drains into IF/ID
  logic w_load;      // any IF/ID load of a real instruction

  assign w_in_fetch = (state_q == S_FETCH);
  assign w_in_hold  = (state_q == S_HOLD);
  assign w_word_ok  = w_in_fetch && imem_ready && !branch_taken && !pend_q;
  assign w_take     = w_word_ok && !stall;
  assign w_park     = w_word_ok && stall;
  assign w_unpark   = w_in_hold && !branch_taken && !stall;
  assign w_load     = w_take || w_unpark;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE is a single post-reset cycle; HOLD parks a word
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (w_park) state_d = S_HOLD;
      S_HOLD:  if (branch_taken || !stall) state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: memory interface and IF/ID outputs
  always_comb begin
    imem_req    = w_in_fetch;
    imem_addr   = fetch_pc_q;
    Instruction = instr_q;
    PC          = pc_q;
    id_valid    = valid_q;
  end

  // Datapath next-state: fetch PC, pending redirect, hold buffer, IF/ID
  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    pend_d       = pend_q;
    pend_addr_d  = pend_addr_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    instr_d      = instr_q;
    pc_d         = pc_q;
    valid_d      = valid_q;

    // Fetch PC only moves when a word comes back (address stable mid-request)
    // or when a redirect arrives outside an outstanding request.
    if (w_in_fetch) begin
      if (imem_ready) begin
        pend_d = 1'b0;
        if (branch_taken) begin
          fetch_pc_d = branch_addr;
        end else if (pend_q) begin
          fetch_pc_d = pend_addr_q;
        end else begin
          fetch_pc_d = fetch_pc_q + PC_STEP;
        end
      end else if (branch_taken) begin
        // A newer redirect simply overwrites an older pending one
        pend_d      = 1'b1;
        pend_addr_d = branch_addr;
      end
    end else if (branch_taken) begin
      fetch_pc_d = branch_addr;
    end

    if (w_park) begin
      hold_instr_d = imem_rdata;
      hold_pc_d    = fetch_pc_q;
    end

    // Redirect beats stall: the flush always wins
    if (branch_taken) begin
      instr_d = NOP_INSTR;
      pc_d    = 12'h000;
      valid_d = 1'b0;
    end else if (w_take) begin
      instr_d = imem_rdata;
      pc_d    = fetch_pc_q;
      valid_d = 1'b1;
    end else if (w_unpark) begin
      instr_d = hold_instr_q;
      pc_d    = hold_pc_q;
      valid_d = 1'b1;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q   <= RESET_PC;
      pend_q       <= 1'b0;
      pend_addr_q  <= 12'h000;
      hold_instr_q <= 32'h0000_0000;
      hold_pc_q    <= 12'h000;
      instr_q      <= NOP_INSTR;
      pc_q         <= 12'h000;
      valid_q      <= 1'b0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      pend_q       <= pend_d;
      pend_addr_q  <= pend_addr_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      instr_q      <= instr_d;
      pc_q         <= pc_d;
      valid_q      <= valid_d;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [15:0] count_q, count_d;

  // Saturating count of real instructions loaded into IF/ID
  always_comb begin
    count_d = count_q;
    if (w_load && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 16'h0000;
    end else begin
      count_q <= count_d;
    end
  end

  assign fetch_count = count_q;
`else
  assign fetch_count = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_stage
// Description : Directed self-checking bench for if_fetch_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [11:0] branch_addr;
  logic        imem_req;
  logic [11:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] Instruction;
  logic [11:0] PC;
  logic        id_valid;
  logic [15:0] fetch_count;

  int n_vec;
  int n_err;
  int exp_loads;

  if_fetch_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .Instruction  (Instruction),
    .PC           (PC),
    .id_valid     (id_valid),
    .fetch_count  (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_cnt(input int loads);
`ifdef IF_PERF_CNT_EN
    return 16'(loads);
`else
    return (loads > 0) ? 16'h0000 : 16'h0000;
`endif
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec = 0; n_err = 0; exp_loads = 0;
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_addr = 12'h000;
    imem_ready = 1'b0; imem_rdata = 32'h0;

    // Reset state
    tick(); tick();
    chk("rst_instr", Instruction, NOP);
    chk("rst_pc", {20'h0, PC}, 32'h000);
    chk("rst_valid", {31'h0, id_valid}, 32'h0);
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_cnt", {16'h0, fetch_count}, 32'h0);

    // Release with ready already high: the IDLE cycle must ignore it
    rst_n = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h11111111;
    tick();
    chk("idle_valid", {31'h0, id_valid}, 32'h0);
    chk("idle_instr", Instruction, NOP);
    chk("f0_req", {31'h0, imem_req}, 32'h1);
    chk("f0_addr", {20'h0, imem_addr}, 32'h000);

    // Zero-wait stream
    imem_rdata = 32'h00A00093;
    tick(); exp_loads++;
    chk("l0_instr", Instruction, 32'h00A00093);
    chk("l0_pc", {20'h0, PC}, 32'h000);
    chk("l0_valid", {31'h0, id_valid}, 32'h1);
    chk("l0_addr", {20'h0, imem_addr}, 32'h004);
    imem_rdata = 32'h00100113;
    tick(); exp_loads++;
    chk("l1_pc", {20'h0, PC}, 32'h004);
    chk("l1_addr", {20'h0, imem_addr}, 32'h008);

    // Stall three cycles as the word for 0x008 returns
    imem_rdata = 32'h00200193; stall = 1'b1;
    tick();
    chk("h0_req", {31'h0, imem_req}, 32'h0);
    chk("h0_pc", {20'h0, PC}, 32'h004);
    chk("h0_instr", Instruction, 32'h00100113);
    imem_rdata = 32'hBAD0BAD0;
    tick();
    chk("h1_pc", {20'h0, PC}, 32'h004);
    chk("h1_req", {31'h0, imem_req}, 32'h0);
    tick();
    chk("h2_pc", {20'h0, PC}, 32'h004);
    stall = 1'b0;
    tick(); exp_loads++;
    chk("h3_pc", {20'h0, PC}, 32'h008);
    chk("h3_instr", Instruction, 32'h00200193);
    chk("h3_addr", {20'h0, imem_addr}, 32'h00C);
    chk("h3_req", {31'h0, imem_req}, 32'h1);

    imem_rdata = 32'h00300213;
    tick(); exp_loads++;
    chk("l3_pc", {20'h0, PC}, 32'h00C);
    imem_rdata = 32'h00400293;
    tick(); exp_loads++;
    chk("l4_pc", {20'h0, PC}, 32'h010);
    chk("l4_addr", {20'h0, imem_addr}, 32'h014);

    // Branch at PC 0x010, same cycle as a returned word
    branch_taken = 1'b1; branch_addr = 12'h040; imem_rdata = 32'h0BADF00D;
    tick();
    branch_taken = 1'b0;
    chk("br_instr", Instruction, NOP);
    chk("br_valid", {31'h0, id_valid}, 32'h0);
    chk("br_pc", {20'h0, PC}, 32'h000);
    chk("br_addr", {20'h0, imem_addr}, 32'h040);
    chk("br_cnt", {16'h0, fetch_count}, {16'h0, exp_cnt(exp_loads)});

    imem_rdata = 32'h00500313;
    tick(); exp_loads++;
    chk("l5_pc", {20'h0, PC}, 32'h040);

    // Redirect to 0x080 while a 3-cycle request is outstanding
    imem_ready = 1'b0; branch_taken = 1'b1; branch_addr = 12'h080;
    tick();
    branch_taken = 1'b0;
    chk("pend_valid", {31'h0, id_valid}, 32'h0);
    chk("pend_addr_stable", {20'h0, imem_addr}, 32'h044);
    tick();
    chk("pend_addr_stable2", {20'h0, imem_addr}, 32'h044);
    imem_ready = 1'b1; imem_rdata = 32'hDEADBEEF;
    tick();
    chk("pend_drop_valid", {31'h0, id_valid}, 32'h0);
    chk("pend_drop_instr", Instruction, NOP);
    chk("pend_new_addr", {20'h0, imem_addr}, 32'h080);

    // Two redirects while pending: the newer target wins
    imem_ready = 1'b0; branch_taken = 1'b1; branch_addr = 12'h0A0;
    tick();
    branch_addr = 12'h0C0;
    tick();
    branch_taken = 1'b0; imem_ready = 1'b1;
    tick();
    chk("pend2_addr", {20'h0, imem_addr}, 32'h0C0);
    chk("pend2_valid", {31'h0, id_valid}, 32'h0);

    // Redirect to 0xFFC coincident with ready, then wrap
    branch_taken = 1'b1; branch_addr = 12'hFFC;
    tick();
    branch_taken = 1'b0;
    chk("wrap_addr0", {20'h0, imem_addr}, 32'hFFC);
    imem_rdata = 32'h00600393;
    tick(); exp_loads++;
    chk("wrap_pc", {20'h0, PC}, 32'hFFC);
    chk("wrap_instr", Instruction, 32'h00600393);
    chk("wrap_addr", {20'h0, imem_addr}, 32'h000);
    imem_rdata = 32'h00700413;
    tick(); exp_loads++;
    chk("wrap_pc2", {20'h0, PC}, 32'h000);

    // Branch while in HOLD discards the parked word
    stall = 1'b1; imem_rdata = 32'h00800493;
    tick();
    chk("hb_req", {31'h0, imem_req}, 32'h0);
    branch_taken = 1'b1; branch_addr = 12'h100;
    tick();
    branch_taken = 1'b0; stall = 1'b0; imem_ready = 1'b0;
    chk("hb_valid", {31'h0, id_valid}, 32'h0);
    chk("hb_req2", {31'h0, imem_req}, 32'h1);
    chk("hb_addr", {20'h0, imem_addr}, 32'h100);
    chk("hb_cnt", {16'h0, fetch_count}, {16'h0, exp_cnt(exp_loads)});

    // Asynchronous reset in the middle of an outstanding request
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req", {31'h0, imem_req}, 32'h0);
    chk("arst_instr", Instruction, NOP);
    chk("arst_pc", {20'h0, PC}, 32'h000);
    chk("arst_valid", {31'h0, id_valid}, 32'h0);
    chk("arst_cnt", {16'h0, fetch_count}, 32'h0);
    tick();
    rst_n = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h12345678;
    tick();
    chk("rel_valid", {31'h0, id_valid}, 32'h0);
    chk("rel_addr", {20'h0, imem_addr}, 32'h000);
    imem_rdata = 32'h00900513;
    tick();
    chk("rel_pc", {20'h0, PC}, 32'h000);
    chk("rel_instr", Instruction, 32'h00900513);
    chk("rel_cnt", {16'h0, fetch_count}, {16'h0, exp_cnt(1)});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/if_fetch_stage.md
IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 12'h000, first fetch address after reset.
REQ-002 Parameter PC_STEP, default 12'd4, sequential PC increment in bytes.
REQ-003 Parameter NOP_INSTR, default 32'h00000013, instruction driven when the IF/ID register is invalid or flushed.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 stall  in  1  hazard hold; IF/ID contents shall not advance while high.
REQ-007 branch_taken  in  1  redirect request from decode (branch and Equal).
REQ-008 branch_addr  in  12  redirect target from decode BranchAddr.
REQ-009 imem_req  out  1  instruction memory request.
REQ-010 imem_addr  out  12  fetch address, valid while imem_req is high.
REQ-011 imem_ready  in  1  one-cycle strobe: imem_rdata valid for the outstanding request.
REQ-012 imem_rdata  in  32  fetched instruction word.
REQ-013 Instruction  out  32  IF/ID instruction, feeds decode.
REQ-014 PC  out  12  IF/ID PC of Instruction, feeds decode.
REQ-015 id_valid  out  1  IF/ID holds a real instruction.
REQ-016 fetch_count  out  16  performance counter (see Configuration).

Function
REQ-017 States IDLE, FETCH, HOLD; IDLE lasts exactly one cycle after reset release, then FETCH.
REQ-018 FETCH: imem_req=1, imem_addr=fetch_pc; both stable until imem_ready (no address change mid-request).
REQ-019 IDLE and HOLD: imem_req=0.
REQ-020 FETCH, imem_ready, no redirect, no pending redirect, stall=0: IF/ID <= {imem_rdata, fetch_pc}, id_valid<=1, fetch_pc += PC_STEP; remain FETCH.
REQ-021 FETCH, imem_ready, stall=1: word and address into hold buffer, fetch_pc += PC_STEP, go HOLD; IF/ID unchanged.
REQ-022 HOLD, stall=0: IF/ID <= hold buffer, id_valid<=1, go FETCH.
REQ-023 branch_taken in any state: IF/ID <= {NOP_INSTR, 12'h000}, id_valid<=0 at the next edge, regardless of stall (redirect beats stall).
REQ-024 branch_taken in FETCH with imem_ready the same cycle: returned word discarded, fetch_pc<=branch_addr.
REQ-025 branch_taken in FETCH without imem_ready: branch_addr latched as pending redirect; on the later imem_ready, word discarded, fetch_pc<=latched target, pending cleared.
REQ-026 Second branch_taken while a redirect is pending: latched target overwritten with the newer branch_addr.
REQ-027 branch_taken in HOLD: buffer discarded, fetch_pc<=branch_addr, go FETCH.
REQ-028 fetch_pc arithmetic is modulo 2^12: 12'hFFC + 4 = 12'h000, no error indication.
REQ-029 stall=1 with no incoming word: Instruction, PC, id_valid held.
REQ-030 Latency: word returned at edge N appears on Instruction after edge N when stall=0; zero-wait memory sustains one instruction per cycle.

Reset
REQ-031 rst_n low asynchronously forces: state=IDLE, fetch_pc=RESET_PC, pending redirect cleared, hold buffer cleared, Instruction=NOP_INSTR, PC=12'h000, id_valid=0, imem_req=0, fetch_count=0.
REQ-032 Reset during an outstanding request abandons it; an imem_ready in the first cycle after release shall be ignored.

Configuration
REQ-033 Macro IF_PERF_CNT_EN defined: fetch_count increments by 1 on every IF/ID load with id_valid<=1, saturating at 16'hFFFF.
REQ-034 Macro IF_PERF_CNT_EN undefined: no counter logic; fetch_count tied to 16'h0000.

Verification
REQ-035 Reset release, imem_ready every FETCH cycle, rdata=32'h00A00093,... -> imem_addr 000,004,008; PC 000,004,008 one cycle behind; id_valid=1 from the first load.
REQ-036 stall=1 for 3 cycles when word at 12'h008 returns -> HOLD entered, imem_req=0, IF/ID holds 12'h004; on release PC=12'h008, then fetch resumes at 12'h00C.
REQ-037 branch_taken=1, branch_addr=12'h040 at PC 12'h010 -> next edge Instruction=32'h00000013, id_valid=0; next imem_addr=12'h040.
REQ-038 branch_taken to 12'h080 while waiting for imem_ready (3-cycle memory) -> returned word dropped, id_valid stays 0, next imem_addr=12'h080.
REQ-039 fetch_pc=12'hFFC, word returned -> PC=12'hFFC, next imem_addr=12'h000.
REQ-040 With IF_PERF_CNT_EN, 5 loads, 1 flush, 2 stall cycles -> fetch_count=5; rst_n pulsed low mid-request -> all REQ-031 values immediately, fetch_count=0.
